// File: rtl/serial_frame_ctrl.sv
// Serial byte framer: SyncByte, length, payload [, XOR checksum] captured into a readable buffer.
// Optional checksum stage is compiled in when SERIAL_FRAME_CHECKSUM_EN is defined.
module serial_frame_ctrl #(
  parameter int Width = 8,
  parameter int MaxLen = 16,
  parameter int TimeoutWidth = 16,
  parameter logic [Width-1:0] SyncByte = Width'(8'hA5),
  localparam int AddrW = (MaxLen > 1) ? $clog2(MaxLen) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_finish,
  input  logic [Width-1:0] rx_data,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [7:0]       frame_len,
  input  logic [AddrW-1:0] rd_addr,
  output logic [Width-1:0] rd_data,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_len,
  output logic             err_chk,
  output logic             overrun,
  output logic [2:0]       dbg_state
);

  // frame_valid/frame_ready: a held frame transfers on any rising clk edge where both
  // are high; frame_valid drops on that edge and frame_len/buffer stay frozen until then.

  localparam int Depth = 1 << AddrW;
  localparam logic [Width-1:0] MaxLenW = Width'(MaxLen);
  localparam logic [TimeoutWidth-1:0] TLast = ~TimeoutWidth'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
`ifdef SERIAL_FRAME_CHECKSUM_EN
    CHECK   = 3'd3,
`endif
    HOLD    = 3'd4
  } state_t;

  state_t                  state;
  logic                    rx_prev;
  logic                    accept;
  logic                    in_window;
  logic                    len_bad;
  logic                    last_byte;
  logic                    wr_en;
  logic [7:0]              idx;
  logic [TimeoutWidth-1:0] tcnt;
  logic [Width-1:0]        mem [Depth];
`ifdef SERIAL_FRAME_CHECKSUM_EN
  logic [Width-1:0]        chk_acc;
`endif

  // rx_prev resets high so a level already asserted at reset release is not an edge.
  assign accept    = rx_finish & ~rx_prev;
  assign len_bad   = (rx_data == '0) || (rx_data > MaxLenW);
  assign last_byte = (idx == (frame_len - 8'd1));
  assign wr_en     = accept && (state == PAYLOAD);
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign rd_data   = mem[rd_addr];

`ifdef SERIAL_FRAME_CHECKSUM_EN
  assign in_window = (state == LEN) || (state == PAYLOAD) || (state == CHECK);
`else
  assign in_window = (state == LEN) || (state == PAYLOAD);
  assign err_chk   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx[AddrW-1:0]] <= rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rx_prev     <= 1'b1;
      frame_valid <= 1'b0;
      frame_len   <= '0;
      idx         <= '0;
      tcnt        <= '0;
      err_timeout <= 1'b0;
      err_len     <= 1'b0;
      overrun     <= 1'b0;
`ifdef SERIAL_FRAME_CHECKSUM_EN
      err_chk     <= 1'b0;
      chk_acc     <= '0;
`endif
    end else begin
      rx_prev     <= rx_finish;
      err_timeout <= 1'b0;
      err_len     <= 1'b0;
      overrun     <= 1'b0;
`ifdef SERIAL_FRAME_CHECKSUM_EN
      err_chk     <= 1'b0;
`endif
      // An accepted byte beats a timeout landing on the same edge.
      if (in_window) begin
        if (accept) begin
          tcnt <= '0;
        end else if (tcnt == TLast) begin
          err_timeout <= 1'b1;
          state       <= IDLE;
          tcnt        <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end

      if (accept) begin
        case (state)
          IDLE: begin
            if (rx_data == SyncByte) begin
              state <= LEN;
              tcnt  <= '0;
            end
          end
          LEN: begin
            if (len_bad) begin
              err_len <= 1'b1;
              state   <= IDLE;
            end else begin
              frame_len <= 8'(rx_data);
              idx       <= '0;
              state     <= PAYLOAD;
`ifdef SERIAL_FRAME_CHECKSUM_EN
              chk_acc   <= rx_data;
`endif
            end
          end
          PAYLOAD: begin
            idx <= idx + 8'd1;
`ifdef SERIAL_FRAME_CHECKSUM_EN
            chk_acc <= chk_acc ^ rx_data;
            if (last_byte) begin
              state <= CHECK;
            end
`else
            if (last_byte) begin
              state       <= HOLD;
              frame_valid <= 1'b1;
            end
`endif
          end
`ifdef SERIAL_FRAME_CHECKSUM_EN
          CHECK: begin
            if (rx_data == chk_acc) begin
              state       <= HOLD;
              frame_valid <= 1'b1;
            end else begin
              err_chk <= 1'b1;
              state   <= IDLE;
            end
          end
`endif
          HOLD: begin
            overrun <= 1'b1;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end

      if ((state == HOLD) && frame_ready) begin
        state       <= IDLE;
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Directed + randomized bench for serial_frame_ctrl against a byte-stream parsing model.
module tb_serial_frame_ctrl;

  localparam int Width = 8;
  localparam int MaxLen = 16;
  localparam int TimeoutWidth = 6;
  localparam int AddrW = 4;
`ifdef SERIAL_FRAME_CHECKSUM_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             rx_finish;
  logic [Width-1:0] rx_data;
  logic             frame_valid;
  logic             frame_ready;
  logic [7:0]       frame_len;
  logic [AddrW-1:0] rd_addr;
  logic [Width-1:0] rd_data;
  logic             busy;
  logic             err_timeout;
  logic             err_len;
  logic             err_chk;
  logic             overrun;
  logic [2:0]       dbg_state;

  serial_frame_ctrl #(
    .Width(Width),
    .MaxLen(MaxLen),
    .TimeoutWidth(TimeoutWidth),
    .SyncByte(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_finish(rx_finish),
    .rx_data(rx_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_len(frame_len),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy(busy),
    .err_timeout(err_timeout),
    .err_len(err_len),
    .err_chk(err_chk),
    .overrun(overrun),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;

  // reference model: parses the accepted byte stream by the framing rules
  bit         m_sync;
  bit         m_hold;
  int         m_len;
  logic [7:0] m_pay[$];
  bit         e_len, e_chk, e_ovr;

  function automatic logic [7:0] model_xor();
    logic [7:0] x = 8'(m_len);
    foreach (m_pay[i]) x = x ^ m_pay[i];
    return x;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    e_len = 1'b0; e_chk = 1'b0; e_ovr = 1'b0;
    if (m_hold) begin
      e_ovr = 1'b1;
    end else if (!m_sync) begin
      if (b == 8'hA5) begin
        m_sync = 1'b1; m_len = 0; m_pay.delete();
      end
    end else if (m_len == 0) begin
      if (b == 8'd0 || b > MaxLen) begin
        e_len = 1'b1; m_sync = 1'b0;
      end else begin
        m_len = b;
      end
    end else if (m_pay.size() < m_len) begin
      m_pay.push_back(b);
      if (m_pay.size() == m_len && !ChkEn) m_hold = 1'b1;
    end else begin
      if (b == model_xor()) m_hold = 1'b1;
      else begin
        e_chk = 1'b1; m_sync = 1'b0;
      end
    end
  endfunction

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pulses(input string tag, input bit tmo);
    check({tag, ".err_len"}, 32'(err_len), 32'(e_len));
    check({tag, ".err_chk"}, 32'(err_chk), 32'(e_chk));
    check({tag, ".overrun"}, 32'(overrun), 32'(e_ovr));
    check({tag, ".err_timeout"}, 32'(err_timeout), 32'(tmo));
    check({tag, ".frame_valid"}, 32'(frame_valid), 32'(m_hold));
    check({tag, ".busy"}, 32'(busy), 32'(m_sync | m_hold));
    if (m_hold) check({tag, ".frame_len"}, 32'(frame_len), 32'(m_len));
  endtask

  task automatic clear_exp();
    e_len = 1'b0; e_chk = 1'b0; e_ovr = 1'b0;
  endtask

  // drivers
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data = b;
    rx_finish = 1'b1;
    @(posedge clk); #1;
    model_byte(b);
    check_pulses("byte", 1'b0);
    @(negedge clk);
    rx_finish = 1'b0;
    rx_data = 8'($urandom);
    @(posedge clk); #1;
    clear_exp();
    check_pulses("after_byte", 1'b0);
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] len, input bit corrupt);
    logic [7:0] q[$];
    logic [7:0] c, p;
    q.push_back(8'hA5);
    q.push_back(len);
    if (len >= 8'd1 && len <= 8'(MaxLen)) begin
      c = len;
      for (int i = 0; i < int'(len); i++) begin
        p = 8'($urandom);
        q.push_back(p);
        c = c ^ p;
      end
      if (ChkEn) q.push_back(corrupt ? (c ^ 8'h5A) : c);
    end
    foreach (q[i]) send_byte(q[i], $urandom_range(0, 2));
  endtask

  task automatic check_buffer(input string tag);
    for (int i = 0; i < m_pay.size(); i++) begin
      @(negedge clk);
      rd_addr = AddrW'(i);
      #1;
      check({tag, ".rd_data"}, 32'(rd_data), 32'(m_pay[i]));
    end
  endtask

  task automatic release_frame();
    @(negedge clk);
    frame_ready = 1'b1;
    @(posedge clk); #1;
    m_hold = 1'b0; m_sync = 1'b0;
    clear_exp();
    check_pulses("release", 1'b0);
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] len;
    m_sync = 1'b0; m_hold = 1'b0; m_len = 0;
    clear_exp();
    rst = 1'b1;
    rx_finish = 1'b0;
    rx_data = '0;
    frame_ready = 1'b0;
    rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_pulses("reset", 1'b0);
    check("reset.frame_len", 32'(frame_len), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // basic frame A5 03 11 22 33 [03]
    send_byte(8'hA5, 1);
    send_byte(8'h03, 0);
    send_byte(8'h11, 2);
    send_byte(8'h22, 0);
    send_byte(8'h33, 1);
`ifdef SERIAL_FRAME_CHECKSUM_EN
    send_byte(8'h03, 0);
`endif
    check("basic.frame_len_3", 32'(frame_len), 32'd3);
    check_buffer("basic");
    repeat (5) @(posedge clk);
    #1;
    check_pulses("basic_hold", 1'b0);
    release_frame();

    // length errors and boundary lengths
    send_byte(8'hA5, 0);
    send_byte(8'h00, 1);
    send_byte(8'hA5, 0);
    send_byte(8'h11, 1);
    send_frame(8'd16, 1'b0);
    check_buffer("len16");
    release_frame();
    send_frame(8'd1, 1'b0);
    check_buffer("len1");
    release_frame();

    // checksum mismatch sequence (a held frame plus overrun without the checksum stage)
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h10, 0);
    send_byte(8'h20, 0);
    send_byte(8'hFF, 1);
    if (m_hold) release_frame();

    // inter-byte timeout
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h10, 0);
    repeat ((1 << TimeoutWidth) - 4) @(posedge clk);
    @(posedge clk); #1;
    check_pulses("tmo_before", 1'b0);
    @(posedge clk); #1;
    m_sync = 1'b0;
    check_pulses("tmo_fire", 1'b1);
    @(posedge clk); #1;
    check_pulses("tmo_clear", 1'b0);
    send_frame(8'd1, 1'b0);
    check_buffer("after_tmo");
    release_frame();

    // byte arriving on the edge the counter saturates wins
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    repeat ((1 << TimeoutWidth) - 3) @(posedge clk);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    if (ChkEn) send_byte(8'h03, 0);
    check_buffer("tmo_race");
    release_frame();

    // overrun while held, then overrun on the handshake edge
    send_frame(8'd4, 1'b0);
    send_byte(8'h5C, 0);
    send_byte(8'hA5, 2);
    check_buffer("overrun");
    @(negedge clk);
    frame_ready = 1'b1;
    rx_data = 8'h77;
    rx_finish = 1'b1;
    @(posedge clk); #1;
    model_byte(8'h77);
    m_hold = 1'b0; m_sync = 1'b0;
    check_pulses("hs_overrun", 1'b0);
    @(negedge clk);
    rx_finish = 1'b0;
    frame_ready = 1'b0;
    @(posedge clk); #1;
    clear_exp();
    check_pulses("hs_after", 1'b0);

    // randomized frames with noise, bad lengths and corrupted checksums
    for (int it = 0; it < 12; it++) begin
      for (int n = 0; n < int'($urandom_range(0, 2)); n++) begin
        do b = 8'($urandom); while (b == 8'hA5);
        send_byte(b, $urandom_range(0, 2));
      end
      if ($urandom_range(0, 3) == 0) begin
        len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MaxLen + 1, 255));
      end else begin
        len = 8'($urandom_range(1, MaxLen));
      end
      send_frame(len, ($urandom_range(0, 3) == 0));
      if (m_hold) begin
        check_buffer("rand");
        release_frame();
      end
    end

    // reset mid-payload with rx_finish held high
    send_byte(8'hA5, 0);
    send_byte(8'h05, 0);
    send_byte(8'h11, 0);
    @(negedge clk);
    rx_data = 8'hA5;
    rx_finish = 1'b1;
    rst = 1'b1;
    #1;
    m_sync = 1'b0; m_hold = 1'b0;
    clear_exp();
    check_pulses("rst_mid", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_pulses("rst_level_high", 1'b0);
    @(negedge clk);
    rx_finish = 1'b0;
    send_frame(8'd2, 1'b0);
    check_buffer("after_rst");
    release_frame();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_frame_ctrl.md
SERIAL_FRAME_CTRL -- requirements
Module: serial_frame_ctrl

Interface
REQ-001 Parameter Width, default 8: byte width of the receiver data path.
REQ-002 Parameter MaxLen, default 16: maximum payload length in bytes; range 1..255.
REQ-003 Parameter TimeoutWidth, default 16: inter-byte timeout counter width.
REQ-004 Parameter SyncByte, default 8'hA5: frame start marker.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 rx_finish  input  1  byte-done level from the serial receiver; stays high until the next start bit.
REQ-008 rx_data  input  Width  received byte; valid while rx_finish is high.
REQ-009 frame_valid  output  1  complete frame held in buffer.
REQ-010 frame_ready  input  1  consumer accepts frame.
REQ-011 frame_len  output  8  payload length of held frame.
REQ-012 rd_addr  input  clog2(MaxLen)  payload buffer read index.
REQ-013 rd_data  output  Width  combinational read of buffer[rd_addr].
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 err_timeout, err_len, err_chk, overrun  output  1 each  single-cycle error pulses.

Function
REQ-016 A byte SHALL be accepted only on a rising edge of rx_finish (registered previous value low, current high); one accept per edge.
REQ-017 States SHALL be IDLE, LEN, PAYLOAD, CHECK, HOLD.
REQ-018 IDLE: accepted byte equal to SyncByte -> LEN; any other byte ignored.
REQ-019 LEN: accepted byte L; L==0 or L>MaxLen -> err_len pulse, IDLE; else store L, index=0, -> PAYLOAD.
REQ-020 PAYLOAD: accepted byte written to buffer[index], index+1; write of index L-1 -> CHECK (macro set) or HOLD (macro clear).
REQ-021 HOLD: frame_valid=1, frame_len=L; transfer completes on a cycle with frame_valid&&frame_ready; next cycle IDLE, frame_valid=0.
REQ-022 frame_valid SHALL rise exactly one cycle after the accepting edge that completes the frame.
REQ-023 Byte accepted while in HOLD, including the handshake cycle, SHALL be dropped and pulse overrun; buffer unchanged.
REQ-024 Timeout counter SHALL clear on every accepted byte and on entry to LEN; increments each cycle in LEN/PAYLOAD/CHECK; on reaching all-ones -> err_timeout pulse, IDLE. No timeout in IDLE or HOLD.
REQ-025 Byte accepted in the same cycle the counter reaches all-ones SHALL win: byte processed, no timeout.
REQ-026 Buffer contents and frame_len SHALL be stable throughout HOLD.

Reset
REQ-027 On rst: state IDLE, frame_valid=0, busy=0, all error pulses 0, frame_len=0, index=0, timeout counter 0.
REQ-028 Previous-rx_finish register SHALL reset to 1 so a level already high at reset release is not an edge.
REQ-029 rst mid-frame SHALL discard the partial frame with no error pulse; buffer contents undefined.

Configuration
REQ-030 Macro SERIAL_FRAME_CHECKSUM_EN defined: CHECK state present; checksum = XOR of L and all payload bytes; accepted byte equal -> HOLD, else err_chk pulse, IDLE.
REQ-031 Macro undefined: no CHECK state, no checksum byte consumed, err_chk tied 0.

Verification
REQ-032 Bytes A5,03,11,22,33,(chk 03 with macro) -> frame_valid 1 cycle after last edge, frame_len=3, rd_data[0..2]=11,22,33.
REQ-033 A5,00 -> err_len single pulse, busy=0 next cycle; A5,11 with MaxLen=16 -> err_len.
REQ-034 Macro set: A5,02,10,20,FF -> err_chk pulse, frame_valid stays 0.
REQ-035 A5,02,10 then no byte for 2^TimeoutWidth-1 cycles -> err_timeout pulse, IDLE; next A5 frame received normally.
REQ-036 frame_ready held 0 in HOLD, two more bytes sent -> two overrun pulses, rd_data unchanged; then frame_ready=1 -> IDLE next cycle.
REQ-037 rst asserted mid-PAYLOAD with rx_finish high -> IDLE, no error pulse, no byte accepted after release until rx_finish falls and rises again.
